fnd_scan_reader: RTL and testbench
==================================

// Module: fnd_scan_reader
// PURPOSE
//  Receive-side counterpart of the FND segment decoder: samples a multiplexed, active-low
//  7-segment bus (seg + one-hot digit common) and recovers the BCD value of every digit.
//  Each digit must read the same pattern on consecutive samples before it is committed.
//  Output is a registered BCD word plus validity/error flags, for self-check and loopback.
// PARAMETERS
//  NUM_DIGITS  4  number of scanned digits (com width, BCD lanes)
//  STABLE_CNT  3  consecutive identical valid samples per digit required to commit (>=1)
// PORTS
//  clk          in   1             system clock, all state on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  sample_en    in   1             sample strobe; seg_in/com_in captured when high
//  seg_in       in   7             segment pattern {g,f,e,d,c,b,a}, active-low (0 = lit)
//  com_in       in   NUM_DIGITS    digit select, one-hot active-high; bit0 = digit 0
//  err_clr      in   1             clears err_pattern and err_com
//  bcd_out      out  4*NUM_DIGITS  committed codes; digit k in bits [4k+3:4k]
//  digit_valid  out  NUM_DIGITS    bit k set once digit k has committed since reset
//  frame_done   out  1             1-cycle pulse: every digit committed since last pulse
//  err_pattern  out  1             sticky: undecodable segment pattern sampled
//  err_com      out  1             sticky: sample_en with com_in not one-hot
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; per-digit candidate=0, count=0;
//   frame mask=0.
//  Decode table (seg_in hex -> code): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 58->7
//   00->8 10->9 7F->F (blank). All other patterns are invalid.
//  Sample: cycle where sample_en=1. Non-one-hot com_in -> sample ignored, err_com set next cycle.
//  One-hot com_in selecting digit k, valid code c:
//   - c == cand[k]: count[k] increments (saturates at STABLE_CNT).
//   - c != cand[k]: cand[k]=c, count[k]=1.
//   - count reaching STABLE_CNT (including STABLE_CNT=1 on first sample) commits: bcd_out
//     lane k = c, digit_valid[k]=1, frame mask[k]=1. Registered, so visible the cycle after
//     the sample edge. A saturated digit re-commits the same value each sample (no change).
//  Invalid pattern on digit k: count[k]=0, cand[k] kept, lane k unchanged, err_pattern set.
//  Samples of other digits never disturb digit k's count.
//  Frame FSM: COLLECT -> FRAME when mask == all ones after a commit; FRAME asserts frame_done
//   for exactly one cycle, clears mask, returns to COLLECT. A commit arriving during FRAME
//   sets its mask bit after the clear, so it is not lost.
//  err_clr: clears both sticky flags. If a new error occurs in the same cycle, set wins.
//  Reset mid-count discards all partial counts. Committed values are not retained.
//  No backpressure: one sample per sample_en, and back-to-back strobes every cycle are legal.
// TESTING
//  1 Reset; for d=0..3 send seg 79,24,30,19 (digit d) x3 each -> bcd_out=16'h4321,
//    digit_valid=4'hF, exactly one frame_done pulse, errors 0.
//  2 Digit1: 24,24,30,30,30 -> lane1 stays 0 until 5th sample, then 3. Code 2 never appears.
//  3 Digit2 seg 7E -> err_pattern=1, lane2 unchanged; then 40 x3 -> lane2=0 (count restarted);
//    err_clr -> err_pattern=0.
//  4 sample_en with com_in=4'b0011 and then 4'b0000 -> err_com=1, no lane/count change;
//    err_clr together with a new bad com -> err_com stays 1.
//  5 Digit3 seg 7F x3 -> lane3=4'hF, digit_valid[3]=1; interleave digit0 samples between
//    them -> digit3 still commits on its 3rd sample.
//  6 Two samples of 10 on digit0, assert rst_n low mid-cycle -> outputs 0 immediately;
//    after release, 2 more samples do not commit, the 3rd commits lane0=9.

Source files
------------

// File: rtl/fnd_scan_if.sv
// Sample/result bundle between a 7-segment bus tap and the scan reader.
interface fnd_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      sample_en;
    logic [6:0]                seg_in;
    logic [NUM_DIGITS-1:0]     com_in;
    logic                      err_clr;
    logic [4*NUM_DIGITS-1:0]   bcd_out;
    logic [NUM_DIGITS-1:0]     digit_valid;
    logic                      frame_done;
    logic                      err_pattern;
    logic                      err_com;

    // Side that samples the segment bus and consumes decoded results.
    modport master (
        output sample_en, seg_in, com_in, err_clr,
        input  bcd_out, digit_valid, frame_done, err_pattern, err_com
    );

    // Reader side.
    modport slave (
        input  sample_en, seg_in, com_in, err_clr,
        output bcd_out, digit_valid, frame_done, err_pattern, err_com
    );
endinterface

// File: rtl/fnd_scan_reader.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus, committing a
// digit only after it reads the same valid pattern on consecutive samples.
module fnd_scan_reader #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    fnd_scan_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

    typedef enum logic {ST_COLLECT, ST_FRAME} state_t;

    state_t                             state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]         cand_q, cand_d;
    logic [NUM_DIGITS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]         bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]              valid_q, valid_d;
    logic [NUM_DIGITS-1:0]              mask_q, mask_d;
    logic [NUM_DIGITS-1:0]              commit_c;
    logic                               frame_q, frame_d;
    logic                               err_pat_q, err_com_q;
    logic                               one_hot_c, code_ok_c, pat_set_c, com_set_c;
    logic [3:0]                         code_c;
    logic [4:0]                         dec_c;

    // {valid, code} for an active-low {g..a} pattern; 7F is a blank digit (code F).
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   return 5'h10;
            7'h79:   return 5'h11;
            7'h24:   return 5'h12;
            7'h30:   return 5'h13;
            7'h19:   return 5'h14;
            7'h12:   return 5'h15;
            7'h02:   return 5'h16;
            7'h58:   return 5'h17;
            7'h00:   return 5'h18;
            7'h10:   return 5'h19;
            7'h7F:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    assign one_hot_c = $onehot(bus.com_in);
    assign dec_c     = decode_seg(bus.seg_in);
    assign code_ok_c = dec_c[4];
    assign code_c    = dec_c[3:0];
    assign pat_set_c = bus.sample_en & one_hot_c & ~code_ok_c;
    assign com_set_c = bus.sample_en & ~one_hot_c;

    // Per-digit candidate/stability tracking and lane commit.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        valid_d  = valid_q;
        commit_c = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (bus.sample_en && one_hot_c && bus.com_in[k]) begin
                if (code_ok_c) begin
                    if (code_c == cand_q[k]) begin
                        if (cnt_q[k] != CNT_W'(STABLE_CNT)) begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end else begin
                        cand_d[k] = code_c;
                        cnt_d[k]  = CNT_W'(1);
                    end
                    if (cnt_d[k] == CNT_W'(STABLE_CNT)) begin
                        commit_c[k] = 1'b1;
                        bcd_d[k]    = code_c;
                        valid_d[k]  = 1'b1;
                    end
                end else begin
                    cnt_d[k] = '0;
                end
            end
        end
    end

    // Frame FSM next state: pulse once all digits have committed; commits during the pulse carry over.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q | commit_c;
        frame_d = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (&mask_d) begin
                    state_d = ST_FRAME;
                    frame_d = 1'b1;
                end
            end
            ST_FRAME: begin
                mask_d  = commit_c;
                state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, mask and sticky error registers; a new error wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q    <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= '0;
            mask_q    <= '0;
            frame_q   <= 1'b0;
            err_pat_q <= 1'b0;
            err_com_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            frame_q   <= frame_d;
            err_pat_q <= pat_set_c | (err_pat_q & ~bus.err_clr);
            err_com_q <= com_set_c | (err_com_q & ~bus.err_clr);
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_q;
    assign bus.err_pattern = err_pat_q;
    assign bus.err_com     = err_com_q;
endmodule

// File: tb/tb_fnd_scan_reader.sv
// Scoreboard bench for fnd_scan_reader: a reference model predicts the outputs of
// every driven cycle; directed tasks add scenario-specific checks.
module tb_fnd_scan_reader;
    localparam int unsigned ND = 4;
    localparam int unsigned SC = 3;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic        errp;
        logic        errc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   frame_cnt = 0;
    exp_t sb_q[$];

    logic [3:0]  m_cand [ND];
    int          m_cnt  [ND];
    logic [15:0] m_bcd;
    logic [3:0]  m_valid;
    logic        m_errp, m_errc;

    always #5 clk = ~clk;

    fnd_scan_if #(.NUM_DIGITS(ND)) bus ();

    fnd_scan_reader #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int ref_decode(input logic [6:0] seg);
        case (seg)
            7'h40: return 0;   7'h79: return 1;   7'h24: return 2;
            7'h30: return 3;   7'h19: return 4;   7'h12: return 5;
            7'h02: return 6;   7'h58: return 7;   7'h00: return 8;
            7'h10: return 9;   7'h7F: return 15;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_cand[i] = 4'h0;
            m_cnt[i]  = 0;
        end
        m_bcd   = '0;
        m_valid = '0;
        m_errp  = 1'b0;
        m_errc  = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic en, input logic [6:0] seg,
                              input logic [3:0] com, input logic clr);
        logic ps, cs;
        int   k, code;
        exp_t e;
        ps = 1'b0;
        cs = 1'b0;
        if (en) begin
            if ($countones(com) == 1) begin
                k = 0;
                for (int i = 0; i < ND; i++) if (com[i]) k = i;
                code = ref_decode(seg);
                if (code < 0) begin
                    m_cnt[k] = 0;
                    ps = 1'b1;
                end else begin
                    if (code == int'(m_cand[k])) begin
                        if (m_cnt[k] < SC) m_cnt[k]++;
                    end else begin
                        m_cand[k] = 4'(code);
                        m_cnt[k]  = 1;
                    end
                    if (m_cnt[k] == SC) begin
                        m_bcd[4*k +: 4] = 4'(code);
                        m_valid[k]      = 1'b1;
                    end
                end
            end else begin
                cs = 1'b1;
            end
        end
        m_errp = ps | (m_errp & ~clr);
        m_errc = cs | (m_errc & ~clr);
        e.bcd   = m_bcd;
        e.valid = m_valid;
        e.errp  = m_errp;
        e.errc  = m_errc;
        sb_q.push_back(e);
    endtask

    // Drive one cycle at the falling edge and post its prediction.
    task automatic drive(input logic en, input logic [6:0] seg,
                         input logic [3:0] com, input logic clr);
        @(negedge clk);
        bus.sample_en = en;
        bus.seg_in    = seg;
        bus.com_in    = com;
        bus.err_clr   = clr;
        model_step(en, seg, com, clr);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.err_clr   = 1'b0;
        bus.com_in    = '0;
        bus.seg_in    = 7'h7F;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: each predicted cycle is checked just after its rising edge.
    always @(posedge clk) begin
        exp_t e, g;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g.bcd   = bus.bcd_out;
            g.valid = bus.digit_valid;
            g.errp  = bus.err_pattern;
            g.errc  = bus.err_com;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t got bcd=%h valid=%b ep=%b ec=%b want bcd=%h valid=%b ep=%b ec=%b",
                         $time, g.bcd, g.valid, g.errp, g.errc, e.bcd, e.valid, e.errp, e.errc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) frame_cnt++;
    end

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.bcd_out, bus.digit_valid, bus.frame_done, bus.err_pattern, bus.err_com} !== 23'h0) begin
            bad++;
            $display("FAIL reset_state got bcd=%h valid=%b fd=%b ep=%b ec=%b want all zero",
                     bus.bcd_out, bus.digit_valid, bus.frame_done, bus.err_pattern, bus.err_com);
        end
    endtask

    task automatic test_full_frame();
        logic [6:0] segs [4];
        segs[0] = 7'h79; segs[1] = 7'h24; segs[2] = 7'h30; segs[3] = 7'h19;
        do_reset();
        frame_cnt = 0;
        for (int d = 0; d < 4; d++)
            for (int r = 0; r < 3; r++)
                drive(1'b1, segs[d], 4'(1 << d), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 7'h7F, 4'h0, 1'b0);
        total++;
        if (bus.bcd_out !== 16'h4321 || bus.digit_valid !== 4'hF) begin
            bad++;
            $display("FAIL full_frame got bcd=%h valid=%b want 4321/1111", bus.bcd_out, bus.digit_valid);
        end
        total++;
        if (frame_cnt !== 1) begin
            bad++;
            $display("FAIL frame_pulses got %0d want 1", frame_cnt);
        end
        total++;
        if (bus.err_pattern !== 1'b0 || bus.err_com !== 1'b0) begin
            bad++;
            $display("FAIL frame_errors got ep=%b ec=%b want 0/0", bus.err_pattern, bus.err_com);
        end
    endtask

    task automatic test_stability();
        logic [6:0] segs [5];
        logic [3:0] want [5];
        segs[0] = 7'h24; segs[1] = 7'h24; segs[2] = 7'h30; segs[3] = 7'h30; segs[4] = 7'h30;
        want[0] = 4'h0;  want[1] = 4'h0;  want[2] = 4'h0;  want[3] = 4'h0;  want[4] = 4'h3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, segs[i], 4'b0010, 1'b0);
            total++;
            if (bus.bcd_out[7:4] !== want[i]) begin
                bad++;
                $display("FAIL stability_%0d got lane1=%h want %h", i, bus.bcd_out[7:4], want[i]);
            end
        end
    endtask

    task automatic test_bad_pattern();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 7'h19, 4'b0100, 1'b0);
        drive(1'b1, 7'h40, 4'b0100, 1'b0);
        drive(1'b1, 7'h40, 4'b0100, 1'b0);
        drive(1'b1, 7'h7E, 4'b0100, 1'b0);
        total++;
        if (bus.err_pattern !== 1'b1 || bus.bcd_out[11:8] !== 4'h4) begin
            bad++;
            $display("FAIL bad_pattern got ep=%b lane2=%h want 1/4", bus.err_pattern, bus.bcd_out[11:8]);
        end
        drive(1'b1, 7'h40, 4'b0100, 1'b0);
        drive(1'b1, 7'h40, 4'b0100, 1'b0);
        total++;
        if (bus.bcd_out[11:8] !== 4'h4) begin
            bad++;
            $display("FAIL count_restart got lane2=%h want 4", bus.bcd_out[11:8]);
        end
        drive(1'b1, 7'h40, 4'b0100, 1'b0);
        total++;
        if (bus.bcd_out[11:8] !== 4'h0) begin
            bad++;
            $display("FAIL recommit got lane2=%h want 0", bus.bcd_out[11:8]);
        end
        drive(1'b0, 7'h7F, 4'h0, 1'b1);
        total++;
        if (bus.err_pattern !== 1'b0) begin
            bad++;
            $display("FAIL pattern_clear got ep=%b want 0", bus.err_pattern);
        end
    endtask

    task automatic test_bad_com();
        do_reset();
        drive(1'b1, 7'h24, 4'b0001, 1'b0);
        drive(1'b1, 7'h24, 4'b0001, 1'b0);
        drive(1'b1, 7'h79, 4'b0011, 1'b0);
        total++;
        if (bus.err_com !== 1'b1 || bus.bcd_out !== 16'h0) begin
            bad++;
            $display("FAIL com_0011 got ec=%b bcd=%h want 1/0000", bus.err_com, bus.bcd_out);
        end
        drive(1'b1, 7'h79, 4'b0000, 1'b0);
        drive(1'b1, 7'h79, 4'b1001, 1'b1);
        total++;
        if (bus.err_com !== 1'b1) begin
            bad++;
            $display("FAIL com_set_wins got ec=%b want 1", bus.err_com);
        end
        drive(1'b1, 7'h24, 4'b0001, 1'b0);
        total++;
        if (bus.bcd_out[3:0] !== 4'h2 || bus.digit_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL com_count_kept got lane0=%h v0=%b want 2/1", bus.bcd_out[3:0], bus.digit_valid[0]);
        end
        drive(1'b0, 7'h7F, 4'h0, 1'b1);
        total++;
        if (bus.err_com !== 1'b0) begin
            bad++;
            $display("FAIL com_clear got ec=%b want 0", bus.err_com);
        end
    endtask

    task automatic test_interleave();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h7F, 4'b1000, 1'b0);
            if (i < 2) drive(1'b1, 7'h12, 4'b0001, 1'b0);
        end
        total++;
        if (bus.bcd_out[15:12] !== 4'hF || bus.digit_valid !== 4'b1000) begin
            bad++;
            $display("FAIL interleave got lane3=%h valid=%b want F/1000", bus.bcd_out[15:12], bus.digit_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 7'h24, 4'b0010, 1'b0);
        drive(1'b1, 7'h10, 4'b0001, 1'b0);
        drive(1'b1, 7'h10, 4'b0001, 1'b0);
        @(negedge clk);
        bus.sample_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.bcd_out !== 16'h0 || bus.digit_valid !== 4'h0) begin
            bad++;
            $display("FAIL async_reset got bcd=%h valid=%b want 0/0", bus.bcd_out, bus.digit_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 7'h10, 4'b0001, 1'b0);
        drive(1'b1, 7'h10, 4'b0001, 1'b0);
        total++;
        if (bus.digit_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL partial_discard got v0=%b want 0", bus.digit_valid[0]);
        end
        drive(1'b1, 7'h10, 4'b0001, 1'b0);
        total++;
        if (bus.bcd_out[3:0] !== 4'h9 || bus.digit_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_commit got lane0=%h v0=%b want 9/1", bus.bcd_out[3:0], bus.digit_valid[0]);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.sample_en = 1'b0;
        bus.seg_in    = 7'h7F;
        bus.com_in    = '0;
        bus.err_clr   = 1'b0;
        model_reset();
        test_reset();
        test_full_frame();
        test_stability();
        test_bad_pattern();
        test_bad_com();
        test_interleave();
        test_reset_mid();
        drive(1'b0, 7'h7F, 4'h0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
